fc_pe_sequencer: RTL

- Control and operand-feed stage directly upstream of the fully-connected multiply-accumulate PE.
- For each output neuron it clears the PE accumulator and streams NUM_INPUTS input/weight pairs from synchronous-read buffers, inserting zero operands in every non-issue cycle.
- After the last pair it waits for the PE pipeline to drain, captures the accumulated 2*DATA_WIDTH result, and presents it on a valid/ready output port.
- It repeats this for NUM_NEURONS neurons per start request.

---
 rtl/fc_pe_sequencer_if.sv | 21 ++
 rtl/fc_pe_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fc_pe_sequencer_if.sv
// Result channel from the FC sequencer to the downstream consumer.
// Latency: none (wires only).
// Backpressure: consumer holds out_ready low to stall; producer keeps payload stable meanwhile.
//
// Signals:
//   out_valid - producer has a captured neuron result
//   out_ready - consumer accepts the result on the edge where both are high
//   out_index - neuron number of out_data
//   out_data  - accumulated result, 2*DATA_WIDTH bits
interface fc_pe_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 3
);
    logic                    out_valid;
    logic                    out_ready;
    logic [IDX_W-1:0]        out_index;
    logic [2*DATA_WIDTH-1:0] out_data;

    modport master (output out_valid, output out_index, output out_data, input out_ready);
    modport slave  (input out_valid, input out_index, input out_data, output out_ready);
endinterface

// File: rtl/fc_pe_sequencer.sv
// Sequencer feeding a multiply-accumulate PE: clears it, streams input/weight pairs, drains, captures the result.
// Latency: per neuron 1 + NUM_INPUTS*ISSUE_GAP + 2 + DRAIN_CYCLES + 1 cycles with out_ready held high.
// Backpressure: stalls in OUTPUT until out_ready; the PE keeps receiving zero operands while stalled.
//
// Ports: clk/rst_n (async active-low); start/busy/done run control; in_addr/in_data and
// w_addr/w_data synchronous-read buffers (data one cycle after address); pe_input/pe_weight/
// pe_start/pe_result to the PE; out_if carries the valid/ready result channel.
module fc_pe_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_INPUTS   = 16,
    parameter int NUM_NEURONS  = 8,
    parameter int ISSUE_GAP    = 1,
    parameter int DRAIN_CYCLES = 2,
    parameter int IN_AW        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    parameter int W_AW         = (NUM_INPUTS * NUM_NEURONS > 1) ? $clog2(NUM_INPUTS * NUM_NEURONS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [IN_AW-1:0]        in_addr,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic [W_AW-1:0]         w_addr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    output logic [DATA_WIDTH-1:0]   pe_input,
    output logic [DATA_WIDTH-1:0]   pe_weight,
    output logic                    pe_start,
    input  logic [2*DATA_WIDTH-1:0] pe_result,
    fc_pe_sequencer_if.master       out_if
);
    localparam int NW        = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int GW        = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam int DRAIN_LEN = 2 + DRAIN_CYCLES;  // 1 cycle buffer read + 1 cycle operand register + PE latency
    localparam int DCW       = $clog2(DRAIN_LEN);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_OUTPUT} state_t;

    state_t                  state_q, state_d;
    logic [NW-1:0]           n_q, n_d;
    logic [IN_AW-1:0]        j_q, j_d;
    logic [GW-1:0]           g_q, g_d;
    logic [DCW-1:0]          d_q, d_d;
    logic [IN_AW-1:0]        in_addr_q, in_addr_d;
    logic [W_AW-1:0]         w_addr_q, w_addr_d;
    logic                    issue_d1_q, issue_d1_d;
    logic [DATA_WIDTH-1:0]   pe_input_q, pe_input_d;
    logic [DATA_WIDTH-1:0]   pe_weight_q, pe_weight_d;
    logic                    out_valid_q, out_valid_d;
    logic [NW-1:0]           out_index_q, out_index_d;
    logic [2*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                    done_q, done_d;
    logic                    issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            j_q         <= '0;
            g_q         <= '0;
            d_q         <= '0;
            in_addr_q   <= '0;
            w_addr_q    <= '0;
            issue_d1_q  <= 1'b0;
            pe_input_q  <= '0;
            pe_weight_q <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            j_q         <= j_d;
            g_q         <= g_d;
            d_q         <= d_d;
            in_addr_q   <= in_addr_d;
            w_addr_q    <= w_addr_d;
            issue_d1_q  <= issue_d1_d;
            pe_input_q  <= pe_input_d;
            pe_weight_q <= pe_weight_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        j_d         = j_q;
        g_d         = g_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        issue = (state_q == S_FEED) && (g_q == '0);

        // Addresses are live in the issue cycle and otherwise hold the last issued value.
        in_addr_d = issue ? j_q : in_addr_q;
        w_addr_d  = issue ? W_AW'(n_q * NUM_INPUTS + j_q) : w_addr_q;

        // Buffer data arrives one cycle after the issue; every other cycle feeds 0*0 to the PE.
        issue_d1_d  = issue;
        pe_input_d  = issue_d1_q ? in_data : '0;
        pe_weight_d = issue_d1_q ? w_data  : '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    n_d     = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                j_d     = '0;
                g_d     = '0;
                d_d     = '0;
            end
            S_FEED: begin
                // j advances at the end of each issue slot, so the slot's last cycle ends FEED.
                if (g_q == GW'(ISSUE_GAP - 1)) begin
                    g_d = '0;
                    if (j_q == IN_AW'(NUM_INPUTS - 1)) begin
                        state_d = S_DRAIN;
                        d_d     = '0;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    g_d = g_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (d_q == DCW'(DRAIN_LEN - 1)) begin
                    state_d     = S_OUTPUT;
                    out_valid_d = 1'b1;
                    out_data_d  = pe_result;
                    out_index_d = n_q;
                end else begin
                    d_d = d_q + 1'b1;
                end
            end
            S_OUTPUT: begin
                if (out_if.out_ready) begin
                    out_valid_d = 1'b0;
                    if (n_q == NW'(NUM_NEURONS - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CLEAR;
                        n_d     = n_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_addr          = in_addr_d;
    assign w_addr           = w_addr_d;
    assign pe_input         = pe_input_q;
    assign pe_weight        = pe_weight_q;
    assign pe_start         = (state_q == S_CLEAR);
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_index = out_index_q;
    assign out_if.out_data  = out_data_q;
endmodule
